// File: rtl/nrisc_ula_wb_pkg.sv
// Shared constants for the nRISC ULA write-back stage: widths, flag layout, branch conditions.
package nrisc_ula_wb_pkg;

  localparam int unsigned TAM    = 16;
  localparam int unsigned RADDR  = 4;
  localparam int unsigned NFLAGS = 3;

  // Flag vector layout is {minus, zero, carry}
  localparam int unsigned FLAG_M = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_NZ     = 3'd2,
    COND_M      = 3'd3,
    COND_NM     = 3'd4,
    COND_C      = 3'd5,
    COND_NC     = 3'd6,
    COND_NEVER  = 3'd7
  } cond_sel_e;

  // Evaluate a branch condition against the architectural flags
  function automatic logic cond_eval(input logic [2:0] sel, input logic [NFLAGS-1:0] flags);
    logic res;
    res = 1'b0;
    case (cond_sel_e'(sel))
      COND_ALWAYS: res = 1'b1;
      COND_Z:      res = flags[FLAG_Z];
      COND_NZ:     res = ~flags[FLAG_Z];
      COND_M:      res = flags[FLAG_M];
      COND_NM:     res = ~flags[FLAG_M];
      COND_C:      res = flags[FLAG_C];
      COND_NC:     res = ~flags[FLAG_C];
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/nrisc_ula_wb_if.sv
// Issue / ULA result / register-file write bus between the pipeline and the write-back stage.
interface nrisc_ula_wb_if #(
  parameter int unsigned TAM   = nrisc_ula_wb_pkg::TAM,
  parameter int unsigned RADDR = nrisc_ula_wb_pkg::RADDR
);
  import nrisc_ula_wb_pkg::NFLAGS;

  logic              issue_valid;
  logic [RADDR-1:0]  issue_rd;
  logic              issue_wreg;
  logic              issue_wflags;
  logic              flush;
  logic              stall;
  logic [TAM-1:0]    ula_out;
  logic [NFLAGS-1:0] ula_flags;
  logic              wb_ready;
  logic              rf_we;
  logic [RADDR-1:0]  rf_addr;
  logic [TAM-1:0]    rf_data;

  modport master (
    output issue_valid, issue_rd, issue_wreg, issue_wflags, flush,
    output ula_out, ula_flags, wb_ready,
    input  stall, rf_we, rf_addr, rf_data
  );

  modport slave (
    input  issue_valid, issue_rd, issue_wreg, issue_wflags, flush,
    input  ula_out, ula_flags, wb_ready,
    output stall, rf_we, rf_addr, rf_data
  );

endinterface

// File: rtl/nrisc_ula_wb_fifo.sv
// Two-entry in-order write-back FIFO; entry 0 is always the head.
module nrisc_wb_fifo #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output logic [W-1:0] tail,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop;

  assign do_pop = pop && (cnt_q != 2'd0);

  // Shift-register update: pops move entry 1 into the head slot
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({push, do_pop})
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = push_data;
        else               e1_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = push_data;
        end else begin
          e0_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  // Upstream stall must prevent pushing into a full FIFO without a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push && (cnt_q == 2'd2) && !do_pop));
    end
  end

  assign head  = e0_q;
  assign tail  = (cnt_q == 2'd2) ? e1_q : e0_q;
  assign count = cnt_q;

endmodule

// File: rtl/nrisc_ula_wb.sv
// ULA write-back stage: tags issued ops, pairs them with the registered ULA result,
// buffers register writes, holds the architectural flags and evaluates branch conditions.
module nrisc_ula_wb
  import nrisc_ula_wb_pkg::*;
#(
  parameter int unsigned TAM   = nrisc_ula_wb_pkg::TAM,
  parameter int unsigned RADDR = nrisc_ula_wb_pkg::RADDR
) (
  input  logic              clk,
  input  logic              rst,
  nrisc_ula_wb_if.slave     bus,
  input  logic [2:0]        cond_sel,
  output logic [NFLAGS-1:0] flags_reg,
  output logic              fwd_valid,
  output logic [RADDR-1:0]  fwd_addr,
  output logic [TAM-1:0]    fwd_data,
  output logic              cond_true
);

  localparam int unsigned W = RADDR + TAM;

  logic              tag_valid_q, tag_valid_d;
  logic [RADDR-1:0]  tag_rd_q, tag_rd_d;
  logic              tag_wreg_q, tag_wreg_d;
  logic              tag_wflags_q, tag_wflags_d;
  logic [NFLAGS-1:0] flags_q, flags_d;

  logic              paired;
  logic              push;
  logic [W-1:0]      head, tail;
  logic [1:0]        count;

  // Tag capture and flag update; a flushed tag is simply dropped
  always_comb begin
    tag_valid_d  = bus.issue_valid && !bus.stall;
    tag_rd_d     = bus.issue_rd;
    tag_wreg_d   = bus.issue_wreg;
    tag_wflags_d = bus.issue_wflags;
    paired       = tag_valid_q && !bus.flush;
    push         = paired && tag_wreg_q;
    flags_d      = flags_q;
    if (paired && tag_wflags_q) flags_d = bus.ula_flags;
  end

  // Tag stage and flags registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_valid_q  <= 1'b0;
      tag_rd_q     <= '0;
      tag_wreg_q   <= 1'b0;
      tag_wflags_q <= 1'b0;
      flags_q      <= '0;
    end else begin
      tag_valid_q  <= tag_valid_d;
      tag_rd_q     <= tag_rd_d;
      tag_wreg_q   <= tag_wreg_d;
      tag_wflags_q <= tag_wflags_d;
      flags_q      <= flags_d;
    end
  end

  nrisc_wb_fifo #(.W(W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (bus.wb_ready),
    .push_data ({tag_rd_q, bus.ula_out}),
    .head      (head),
    .tail      (tail),
    .count     (count)
  );

  // Pending tag counts against FIFO space so its push can never overflow
  assign bus.stall   = (3'(count) + 3'(tag_valid_q)) >= 3'd2;
  assign bus.rf_we   = (count != 2'd0);
  assign bus.rf_addr = head[W-1 -: RADDR];
  assign bus.rf_data = head[TAM-1:0];

  assign fwd_valid = (count != 2'd0);
  assign fwd_addr  = tail[W-1 -: RADDR];
  assign fwd_data  = tail[TAM-1:0];

  assign flags_reg = flags_q;
  assign cond_true = cond_eval(cond_sel, flags_q);

endmodule

// File: tb/tb_nrisc_ula_wb.sv
// Directed bench for the nRISC ULA write-back stage.
module tb_nrisc_ula_wb;
  import nrisc_ula_wb_pkg::*;

  logic              clk;
  logic              rst;
  logic [2:0]        cond_sel;
  logic [NFLAGS-1:0] flags_reg;
  logic              fwd_valid;
  logic [RADDR-1:0]  fwd_addr;
  logic [TAM-1:0]    fwd_data;
  logic              cond_true;

  int checks;
  int failures;

  nrisc_ula_wb_if bus ();

  nrisc_ula_wb dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cond_sel  (cond_sel),
    .flags_reg (flags_reg),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .cond_true (cond_true)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] rd, input logic wreg, input logic wflags);
    bus.issue_valid  = 1'b1;
    bus.issue_rd     = rd;
    bus.issue_wreg   = wreg;
    bus.issue_wflags = wflags;
  endtask

  localparam logic [2:0] COND_EXP [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    cond_sel = 3'd0;
    bus.issue_valid = 1'b0;
    bus.issue_rd = '0;
    bus.issue_wreg = 1'b0;
    bus.issue_wflags = 1'b0;
    bus.flush = 1'b0;
    bus.ula_out = '0;
    bus.ula_flags = '0;
    bus.wb_ready = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_flags", 32'(flags_reg), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_rf_data", 32'(bus.rf_data), 32'd0);
    chk("rst_cond_true", 32'(cond_true), 32'd1);
    rst = 1'b1;
    step();

    // Test 1: single op, two-cycle latency to rf_we
    bus.wb_ready = 1'b1;
    issue(4'd3, 1'b1, 1'b1);
    step();
    bus.issue_valid = 1'b0;
    bus.ula_out = 16'h1234;
    bus.ula_flags = 3'b001;
    chk("t1_we_at_issue1", 32'(bus.rf_we), 32'd0);
    chk("t1_stall", 32'(bus.stall), 32'd0);
    step();
    chk("t1_we_at_issue2", 32'(bus.rf_we), 32'd1);
    chk("t1_rf_addr", 32'(bus.rf_addr), 32'd3);
    chk("t1_rf_data", 32'(bus.rf_data), 32'h1234);
    chk("t1_flags", 32'(flags_reg), 32'b001);
    chk("t1_fwd_addr", 32'(fwd_addr), 32'd3);
    cond_sel = 3'd5;
    #1;
    chk("t1_cond_c", 32'(cond_true), 32'd1);
    cond_sel = 3'd0;
    step();
    chk("t1_popped", 32'(bus.rf_we), 32'd0);

    // Test 2: back-pressure, two buffered writes drain in order
    bus.wb_ready = 1'b0;
    issue(4'd1, 1'b1, 1'b0);
    step();
    chk("t2_stall_first", 32'(bus.stall), 32'd0);
    issue(4'd2, 1'b1, 1'b0);
    bus.ula_out = 16'h1111;
    step();
    chk("t2_stall_issue1", 32'(bus.stall), 32'd1);
    chk("t2_head_addr", 32'(bus.rf_addr), 32'd1);
    chk("t2_head_data", 32'(bus.rf_data), 32'h1111);
    bus.issue_valid = 1'b0;
    bus.ula_out = 16'h2222;
    step();
    chk("t2_stall_full", 32'(bus.stall), 32'd1);
    chk("t2_fwd_addr", 32'(fwd_addr), 32'd2);
    chk("t2_fwd_data", 32'(fwd_data), 32'h2222);
    step();
    chk("t2_hold_addr", 32'(bus.rf_addr), 32'd1);
    chk("t2_hold_we", 32'(bus.rf_we), 32'd1);
    bus.wb_ready = 1'b1;
    step();
    chk("t2_second_we", 32'(bus.rf_we), 32'd1);
    chk("t2_second_addr", 32'(bus.rf_addr), 32'd2);
    chk("t2_second_data", 32'(bus.rf_data), 32'h2222);
    chk("t2_stall_drain", 32'(bus.stall), 32'd0);
    step();
    chk("t2_empty", 32'(bus.rf_we), 32'd0);
    chk("t2_flags_kept", 32'(flags_reg), 32'b001);

    // Test 3: flushed op leaves no trace
    issue(4'd5, 1'b1, 1'b1);
    step();
    bus.issue_valid = 1'b0;
    bus.flush = 1'b1;
    bus.ula_out = 16'h5555;
    bus.ula_flags = 3'b110;
    step();
    bus.flush = 1'b0;
    chk("t3_no_we", 32'(bus.rf_we), 32'd0);
    chk("t3_flags", 32'(flags_reg), 32'b001);
    step();
    chk("t3_no_we_late", 32'(bus.rf_we), 32'd0);

    // Flags-only op loads 010 for the condition table
    issue(4'd7, 1'b0, 1'b1);
    step();
    bus.issue_valid = 1'b0;
    bus.ula_flags = 3'b010;
    step();
    chk("t4_flags", 32'(flags_reg), 32'b010);

    // Test 4: condition table against flags 010 (Z set)
    for (int s = 0; s < 8; s++) begin
      cond_sel = 3'(s);
      #1;
      chk($sformatf("t4_cond_sel%0d", s), 32'(cond_true), 32'(COND_EXP[s]));
    end
    cond_sel = 3'd0;

    // Test 6: flags-only op never writes the register file
    issue(4'd6, 1'b0, 1'b1);
    step();
    bus.issue_valid = 1'b0;
    bus.ula_flags = 3'b100;
    step();
    chk("t6_flags", 32'(flags_reg), 32'b100);
    chk("t6_no_we", 32'(bus.rf_we), 32'd0);
    chk("t6_no_fwd", 32'(fwd_valid), 32'd0);
    cond_sel = 3'd3;
    #1;
    chk("t6_cond_m", 32'(cond_true), 32'd1);
    cond_sel = 3'd0;

    // Test 5: reset discards buffered writes and flags
    bus.wb_ready = 1'b0;
    issue(4'd8, 1'b1, 1'b1);
    step();
    issue(4'd9, 1'b1, 1'b0);
    bus.ula_out = 16'h8888;
    bus.ula_flags = 3'b011;
    step();
    bus.issue_valid = 1'b0;
    bus.ula_out = 16'h9999;
    step();
    chk("t5_full_stall", 32'(bus.stall), 32'd1);
    chk("t5_full_flags", 32'(flags_reg), 32'b011);
    rst = 1'b0;
    step();
    chk("t5_rst_we", 32'(bus.rf_we), 32'd0);
    chk("t5_rst_stall", 32'(bus.stall), 32'd0);
    chk("t5_rst_flags", 32'(flags_reg), 32'd0);
    chk("t5_rst_fwd", 32'(fwd_valid), 32'd0);
    chk("t5_rst_data", 32'(bus.rf_data), 32'd0);
    chk("t5_rst_cond", 32'(cond_true), 32'd1);
    rst = 1'b1;
    bus.wb_ready = 1'b1;
    step();
    chk("t5_after_release", 32'(bus.rf_we), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
